// File: rtl/regression_pkg.sv
// Shared types for the linear-regression control sequencer.
// State encoding is exported on the debug stage port.
package regression_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRANSPOSE = 3'd1,
    MULTIPLY  = 3'd2,
    INVERT    = 3'd3,
    FINAL     = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam int TMR_W = 8;

  function automatic logic is_busy(input state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/regression_sequencer_stage_timer.sv
// Per-stage watchdog: counts busy cycles since the last state entry.
// Expired is asserted on the terminal-count cycle itself.
module stage_timer
  import regression_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] TC = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TC)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == TC);

endmodule

// File: rtl/regression_sequencer.sv
// Control FSM for the regression datapath: sequences the stage
// start/done handshakes and flags singular or stalled runs.
module regression_sequencer
  import regression_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       data_ready,
  input  logic       done_transpose,
  input  logic       done_xtx,
  input  logic       done_xty,
  input  logic       done_inverse,
  input  logic       inv_invalid,
  input  logic       done_final,
  output logic       start_transpose,
  output logic       start_multiply,
  output logic       start_inverse,
  output logic       start_final,
  output logic       busy,
  output logic       done,
  output logic       result_valid,
  output logic       error_singular,
  output logic       error_timeout,
  output logic [2:0] stage
);

  state_t r_state;
  state_t w_next;

  logic r_xtx;
  logic r_xty;
  logic r_st_t;
  logic r_st_m;
  logic r_st_i;
  logic r_st_f;
  logic r_busy;
  logic r_done;
  logic r_valid;
  logic r_sing;
  logic r_tout;

  logic w_accept;
  logic w_mult_done;
  logic w_expired;
  logic w_clear;
  logic w_set_sing;
  logic w_set_tout;
  logic w_enter;

  assign w_accept = start && data_ready && !is_busy(r_state);
  assign w_mult_done = (r_xtx || done_xtx) && (r_xty || done_xty);
  assign w_clear = (w_next != r_state);
  assign w_enter = (w_next != r_state);

  stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (is_busy(r_state)),
    .o_expired(w_expired)
  );

  // A stage done on the terminal-count cycle takes priority over timeout.
  always_comb begin
    w_next = r_state;
    w_set_sing = 1'b0;
    w_set_tout = 1'b0;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_accept) w_next = TRANSPOSE;
        end
        TRANSPOSE: begin
          if (done_transpose) begin
            w_next = MULTIPLY;
          end else if (w_expired) begin
            w_next = ERROR;
            w_set_tout = 1'b1;
          end
        end
        MULTIPLY: begin
          if (w_mult_done) begin
            w_next = INVERT;
          end else if (w_expired) begin
            w_next = ERROR;
            w_set_tout = 1'b1;
          end
        end
        INVERT: begin
          if (done_inverse) begin
            if (inv_invalid) begin
              w_next = ERROR;
              w_set_sing = 1'b1;
            end else begin
              w_next = FINAL;
            end
          end else if (w_expired) begin
            w_next = ERROR;
            w_set_tout = 1'b1;
          end
        end
        FINAL: begin
          if (done_final) begin
            w_next = DONE;
          end else if (w_expired) begin
            w_next = ERROR;
            w_set_tout = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_xtx   <= 1'b0;
      r_xty   <= 1'b0;
      r_st_t  <= 1'b0;
      r_st_m  <= 1'b0;
      r_st_i  <= 1'b0;
      r_st_f  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_sing  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_st_t  <= w_enter && (w_next == TRANSPOSE);
      r_st_m  <= w_enter && (w_next == MULTIPLY);
      r_st_i  <= w_enter && (w_next == INVERT);
      r_st_f  <= w_enter && (w_next == FINAL);
      r_busy  <= is_busy(w_next);
      r_done  <= w_enter && (w_next == DONE);

      // Multiply completions only count while MULTIPLY is current.
      if ((r_state == MULTIPLY) && (w_next == MULTIPLY)) begin
        if (done_xtx) r_xtx <= 1'b1;
        if (done_xty) r_xty <= 1'b1;
      end else begin
        r_xtx <= 1'b0;
        r_xty <= 1'b0;
      end

      if (abort || w_accept) begin
        r_valid <= 1'b0;
      end else if (w_enter && (w_next == DONE)) begin
        r_valid <= 1'b1;
      end

      if (abort || w_accept) begin
        r_sing <= 1'b0;
        r_tout <= 1'b0;
      end else begin
        if (w_set_sing) r_sing <= 1'b1;
        if (w_set_tout) r_tout <= 1'b1;
      end
    end
  end

  assign start_transpose = r_st_t;
  assign start_multiply  = r_st_m;
  assign start_inverse   = r_st_i;
  assign start_final     = r_st_f;
  assign busy            = r_busy;
  assign done            = r_done;
  assign result_valid    = r_valid;
  assign error_singular  = r_sing;
  assign error_timeout   = r_tout;
  assign stage           = r_state;

endmodule

// File: tb/tb_regression_sequencer.sv
// Scoreboarded bench for regression_sequencer with a
// latency-programmable model of the datapath stages.
module tb_regression_sequencer;
  import regression_pkg::*;

  localparam int EV_ST = 1;
  localparam int EV_SM = 2;
  localparam int EV_SI = 3;
  localparam int EV_SF = 4;
  localparam int EV_DN = 5;
  localparam int EV_ES = 6;
  localparam int EV_ET = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic data_ready = 1'b0;
  logic done_transpose = 1'b0;
  logic done_xtx = 1'b0;
  logic done_xty = 1'b0;
  logic done_inverse = 1'b0;
  logic inv_invalid = 1'b0;
  logic done_final = 1'b0;
  logic start_transpose;
  logic start_multiply;
  logic start_inverse;
  logic start_final;
  logic busy;
  logic done;
  logic result_valid;
  logic error_singular;
  logic error_timeout;
  logic [2:0] stage;

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_t = 2;
  int lat_x = 2;
  int lat_y = 2;
  int lat_i = 2;
  int lat_f = 2;
  bit inv_bad = 1'b0;
  int cnt_t = 0;
  int cnt_x = 0;
  int cnt_y = 0;
  int cnt_i = 0;
  int cnt_f = 0;
  bit p_sing = 1'b0;
  bit p_tout = 1'b0;
  int t0;

  always #5 clk = ~clk;

  regression_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .data_ready     (data_ready),
    .done_transpose (done_transpose),
    .done_xtx       (done_xtx),
    .done_xty       (done_xty),
    .done_inverse   (done_inverse),
    .inv_invalid    (inv_invalid),
    .done_final     (done_final),
    .start_transpose(start_transpose),
    .start_multiply (start_multiply),
    .start_inverse  (start_inverse),
    .start_final    (start_final),
    .busy           (busy),
    .done           (done),
    .result_valid   (result_valid),
    .error_singular (error_singular),
    .error_timeout  (error_timeout),
    .stage          (stage)
  );

  function automatic int outs();
    return int'({start_transpose, start_multiply, start_inverse,
                 start_final, busy, done, result_valid,
                 error_singular, error_timeout, stage});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stage model: done arrives lat cycles after the start pulse; 0 = never.
  initial forever begin
    @(negedge clk);
    if (start_transpose) cnt_t = lat_t;
    if (start_multiply) begin
      cnt_x = lat_x;
      cnt_y = lat_y;
    end
    if (start_inverse) cnt_i = lat_i;
    if (start_final) cnt_f = lat_f;
    @(posedge clk);
    #1;
    done_transpose = 1'b0;
    done_xtx = 1'b0;
    done_xty = 1'b0;
    done_inverse = 1'b0;
    inv_invalid = 1'b0;
    done_final = 1'b0;
    if (cnt_t > 0) begin
      cnt_t--;
      if (cnt_t == 0) done_transpose = 1'b1;
    end
    if (cnt_x > 0) begin
      cnt_x--;
      if (cnt_x == 0) done_xtx = 1'b1;
    end
    if (cnt_y > 0) begin
      cnt_y--;
      if (cnt_y == 0) done_xty = 1'b1;
    end
    if (cnt_i > 0) begin
      cnt_i--;
      if (cnt_i == 0) begin
        done_inverse = 1'b1;
        inv_invalid = inv_bad;
      end
    end
    if (cnt_f > 0) begin
      cnt_f--;
      if (cnt_f == 0) done_final = 1'b1;
    end
  end

  task automatic chk_ev(input int code);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got code=%0d at cyc=%0d, expected none",
               code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.code != code || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got code=%0d cyc=%0d, want code=%0d cyc=%0d",
                 code, cyc, e.code, e.cyc);
      end
    end
  endtask

  // Monitor: every observable pulse or flag rise is matched in order.
  initial forever begin
    @(negedge clk);
    if (start_transpose) chk_ev(EV_ST);
    if (start_multiply) chk_ev(EV_SM);
    if (start_inverse) chk_ev(EV_SI);
    if (start_final) chk_ev(EV_SF);
    if (done) chk_ev(EV_DN);
    if (error_singular && !p_sing) chk_ev(EV_ES);
    if (error_timeout && !p_tout) chk_ev(EV_ET);
    p_sing = error_singular;
    p_tout = error_timeout;
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc=%0d)", nm, act, want, cyc);
    end
  endtask

  task automatic push(input int code, input int c);
    exp_q.push_back('{code, c});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic kick(output int t);
    t = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_full(input int t, input int m, input int i,
                           input int f, input int d);
    push(EV_ST, t);
    push(EV_SM, m);
    push(EV_SI, i);
    push(EV_SF, f);
    push(EV_DN, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    step();
    rst = 1'b0;

    // Nominal, every stage answers 2 cycles after its start
    step();
    kick(t0);
    push_full(t0 + 1, t0 + 4, t0 + 7, t0 + 10, t0 + 13);
    at(t0 + 5);
    chk("nom_busy", int'(busy), 1);
    at(t0 + 14);
    chk("nom_idle_busy", int'(busy), 0);
    chk("nom_valid", int'(result_valid), 1);
    chk("nom_stage", int'(stage), int'(DONE));
    at(t0 + 20);
    chk("nom_valid_hold", int'(result_valid), 1);

    // Skewed multiply completions
    step();
    lat_x = 1;
    lat_y = 5;
    kick(t0);
    push_full(t0 + 1, t0 + 4, t0 + 10, t0 + 13, t0 + 16);
    at(t0 + 2);
    chk("skew_valid_clr", int'(result_valid), 0);
    at(t0 + 9);
    chk("skew_hold", int'(stage), int'(MULTIPLY));
    at(t0 + 17);
    chk("skew_valid", int'(result_valid), 1);
    lat_x = 2;
    lat_y = 2;

    // Singular inverse
    step();
    inv_bad = 1'b1;
    kick(t0);
    push(EV_ST, t0 + 1);
    push(EV_SM, t0 + 4);
    push(EV_SI, t0 + 7);
    push(EV_ES, t0 + 10);
    at(t0 + 12);
    chk("sing_stage", int'(stage), int'(ERROR));
    chk("sing_busy", int'(busy), 0);
    chk("sing_flag", int'(error_singular), 1);
    chk("sing_tout", int'(error_timeout), 0);
    chk("sing_valid", int'(result_valid), 0);
    inv_bad = 1'b0;

    // Transpose never answers
    step();
    lat_t = 0;
    kick(t0);
    push(EV_ST, t0 + 1);
    push(EV_ET, t0 + 17);
    at(t0 + 2);
    chk("sing_cleared", int'(error_singular), 0);
    at(t0 + 16);
    chk("tout_pending", int'(stage), int'(TRANSPOSE));
    chk("tout_not_yet", int'(error_timeout), 0);
    at(t0 + 18);
    chk("tout_flag", int'(error_timeout), 1);
    chk("tout_stage", int'(stage), int'(ERROR));

    // Done on the terminal-count cycle wins
    step();
    lat_t = 15;
    kick(t0);
    push_full(t0 + 1, t0 + 17, t0 + 20, t0 + 23, t0 + 26);
    at(t0 + 2);
    chk("win_tout_clr", int'(error_timeout), 0);
    at(t0 + 27);
    chk("win_no_tout", int'(error_timeout), 0);
    chk("win_valid", int'(result_valid), 1);
    lat_t = 2;

    // Abort during INVERT
    step();
    kick(t0);
    push(EV_ST, t0 + 1);
    push(EV_SM, t0 + 4);
    push(EV_SI, t0 + 7);
    at(t0 + 2);
    chk("abort_valid_clr", int'(result_valid), 0);
    at(t0 + 7);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    at(t0 + 9);
    chk("abort_stage", int'(stage), int'(IDLE));
    chk("abort_busy", int'(busy), 0);
    at(t0 + 12);
    chk("abort_stays", int'(stage), int'(IDLE));

    // Start while busy is ignored
    step();
    kick(t0);
    push_full(t0 + 1, t0 + 4, t0 + 7, t0 + 10, t0 + 13);
    at(t0 + 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    at(t0 + 14);
    chk("busy_start_stage", int'(stage), int'(DONE));

    // Start without data_ready is ignored
    step();
    data_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    at(t0 + 3);
    chk("nodata_stage", int'(stage), int'(DONE));
    chk("nodata_valid", int'(result_valid), 1);
    data_ready = 1'b1;

    // Asynchronous reset in FINAL
    step();
    lat_f = 6;
    kick(t0);
    push(EV_ST, t0 + 1);
    push(EV_SM, t0 + 4);
    push(EV_SI, t0 + 7);
    push(EV_SF, t0 + 10);
    at(t0 + 10);
    step();
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), 0);
    at(t0 + 12);
    step();
    rst = 1'b0;
    at(t0 + 18);
    chk("rst_stage", int'(stage), int'(IDLE));
    chk("rst_valid", int'(result_valid), 0);
    lat_f = 2;

    at(cyc + 3);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
